// File: rtl/lcm_unit.sv
// LCM stage fed by the upstream GCD block: lcm = (inA / gcd) * inB using a
// 16-step restoring divider followed by a 16-step shift-add multiplier.
module lcm_unit #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   inA,
    input  logic [WIDTH-1:0]   inB,
    input  logic [WIDTH-1:0]   gcd,
    output logic [2*WIDTH-1:0] lcm,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        MUL,
        DONE
    } state_t;

    state_t state, nextState;

    // regA holds the dividend during DIV; quotient bits shift in behind it,
    // so by MUL it holds the quotient and serves as the multiplier.
    logic [WIDTH-1:0]   regA;
    logic [WIDTH-1:0]   regG;
    logic [WIDTH:0]     rem;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [CW-1:0]      step;

    logic               zeroIn;
    logic               lastStep;
    logic [WIDTH:0]     remShift;
    logic               remGe;
    logic [WIDTH:0]     remNext;
    logic [2*WIDTH-1:0] accNext;

    assign zeroIn   = (inA == '0) || (inB == '0) || (gcd == '0);
    assign lastStep = (step == LAST_STEP);
    assign remShift = (rem << 1) | {{WIDTH{1'b0}}, regA[WIDTH-1]};
    assign remGe    = (remShift >= {1'b0, regG});
    assign remNext  = remGe ? (remShift - {1'b0, regG}) : remShift;
    assign accNext  = regA[0] ? (acc + mcand) : acc;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = zeroIn ? DONE : DIV;
                end
            end
            DIV: begin
                if (lastStep) begin
                    nextState = MUL;
                end
            end
            MUL: begin
                if (lastStep) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // lcm is loaded on the final MUL edge so it is already valid while done is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regA  <= '0;
            regG  <= '0;
            rem   <= '0;
            acc   <= '0;
            mcand <= '0;
            step  <= '0;
            lcm   <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        regA  <= inA;
                        regG  <= gcd;
                        mcand <= {{WIDTH{1'b0}}, inB};
                        rem   <= '0;
                        acc   <= '0;
                        step  <= '0;
                        lcm   <= '0;
                        err   <= (gcd == '0);
                    end
                end
                DIV: begin
                    rem  <= remNext;
                    regA <= {regA[WIDTH-2:0], remGe};
                    step <= step + CW'(1);
                    if (lastStep && (remNext != '0)) begin
                        err <= 1'b1;
                    end
                end
                MUL: begin
                    acc   <= accNext;
                    mcand <= mcand << 1;
                    regA  <= regA >> 1;
                    step  <= step + CW'(1);
                    if (lastStep) begin
                        lcm <= err ? '0 : accNext;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcm_unit.sv
// Self-checking bench for lcm_unit: an arithmetic reference model checked every
// cycle, plus directed cases with hand-computed results and latencies.
module tb_lcm_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] inA;
    logic [15:0] inB;
    logic [15:0] gcd;
    logic [31:0] lcm;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lcm_unit #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .inA   (inA),
        .inB   (inB),
        .gcd   (gcd),
        .lcm   (lcm),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: result, error flag and cycles-to-done straight from the arithmetic.
    function automatic void modelOp(input logic [15:0] a, input logic [15:0] b, input logic [15:0] g,
                                    output logic [31:0] r, output logic e, output int lat);
        logic [31:0] q;
        if (g == 0) begin
            r = 0; e = 1'b1; lat = 1;
        end else if (a == 0 || b == 0) begin
            r = 0; e = 1'b0; lat = 1;
        end else if (a % g != 0) begin
            r = 0; e = 1'b1; lat = 33;
        end else begin
            q = {16'd0, a / g};
            r = q * {16'd0, b};
            e = 1'b0;
            lat = 33;
        end
    endfunction

    logic        mBusy;
    int          mCnt;
    int          mLat;
    logic [31:0] mLcm;
    logic [31:0] mRes;
    logic        mErr;
    logic        mErrRes;

    // mCnt counts cycles left until idle; the result appears when it reaches 1.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mBusy = 1'b0;
            mCnt  = 0;
            mLcm  = 0;
            mErr  = 1'b0;
        end else if (!mBusy) begin
            if (start) begin
                modelOp(inA, inB, gcd, mRes, mErrRes, mLat);
                mBusy = 1'b1;
                mCnt  = mLat;
                mLcm  = 0;
                mErr  = 1'b0;
                if (mCnt == 1) begin
                    mLcm = mRes;
                    mErr = mErrRes;
                end
            end
        end else begin
            mCnt--;
            if (mCnt == 1) begin
                mLcm = mRes;
                mErr = mErrRes;
            end
            if (mCnt == 0) begin
                mBusy = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            checkOutput("modelBusy", busy, mBusy);
            checkOutput("modelDone", done, mBusy && (mCnt == 1));
            checkOutput("modelLcm", lcm, mLcm);
            if (!mBusy || mCnt == 1) begin
                checkOutput("modelErr", err, mErr);
            end
        end
    end

    // Drives a one-cycle start pulse; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [15:0] g);
        @(negedge clk);
        inA   = a;
        inB   = b;
        gcd   = g;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // lat counts cycles from the start edge through the done cycle (short path = 1).
    task automatic waitDone(output int lat, output int busyCycles);
        lat        = 1;
        busyCycles = busy ? 1 : 0;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busyCycles++;
        end
        checkOutput("doneSeen", done, 1'b1);
    endtask

    task automatic runCase(input string name, input logic [15:0] a, input logic [15:0] b, input logic [15:0] g,
                           input logic [31:0] expLcm, input logic expErr, input int expLat);
        int lat;
        int bc;
        applyStimulus(a, b, g);
        waitDone(lat, bc);
        checkOutput({name, "Latency"}, lat, expLat);
        checkOutput({name, "Lcm"}, lcm, expLcm);
        checkOutput({name, "Err"}, err, expErr);
        @(posedge clk);
        #1;
        checkOutput({name, "DonePulse"}, done, 1'b0);
        checkOutput({name, "IdleBusy"}, busy, 1'b0);
    endtask

    initial begin
        int lat;
        int bc;
        rst   = 1'b1;
        start = 1'b0;
        inA   = '0;
        inB   = '0;
        gcd   = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetBusy", busy, 1'b0);
        checkOutput("resetDone", done, 1'b0);
        checkOutput("resetErr", err, 1'b0);
        checkOutput("resetLcm", lcm, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(16'd8, 16'd6, 16'd2);
        waitDone(lat, bc);
        checkOutput("basicLatency", lat, 33);
        checkOutput("basicBusyCycles", bc, 33);
        checkOutput("basicLcm", lcm, 32'd24);
        checkOutput("basicErr", err, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("basicIdle", busy, 1'b0);

        runCase("coprime", 16'd14, 16'd15, 16'd1, 32'd210, 1'b0, 33);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("coprimeHold", lcm, 32'd210);

        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("idleResetLcm", lcm, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        runCase("wide", 16'd65535, 16'd65534, 16'd1, 32'hFFFD0002, 1'b0, 33);
        runCase("zeroA", 16'd0, 16'd5, 16'd5, 32'd0, 1'b0, 1);
        runCase("zeroGcd", 16'd7, 16'd3, 16'd0, 32'd0, 1'b1, 1);
        runCase("badGcd", 16'd8, 16'd6, 16'd3, 32'd0, 1'b1, 33);

        applyStimulus(16'd8, 16'd6, 16'd2);
        repeat (4) @(posedge clk);
        @(negedge clk);
        inA   = 16'd100;
        inB   = 16'd7;
        gcd   = 16'd50;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(lat, bc);
        checkOutput("ignoredStartLat", lat, 28);
        checkOutput("ignoredStartLcm", lcm, 32'd24);
        checkOutput("ignoredStartErr", err, 1'b0);
        @(posedge clk);
        #1;

        applyStimulus(16'd8, 16'd6, 16'd2);
        repeat (9) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncRstBusy", busy, 1'b0);
        checkOutput("asyncRstDone", done, 1'b0);
        checkOutput("asyncRstErr", err, 1'b0);
        checkOutput("asyncRstLcm", lcm, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("postRstIdle", busy, 1'b0);
        runCase("afterRst", 16'd14, 16'd15, 16'd1, 32'd210, 1'b0, 33);

        @(negedge clk);
        inA   = 16'd12;
        inB   = 16'd18;
        gcd   = 16'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        waitDone(lat, bc);
        checkOutput("b2bFirstLcm", lcm, 32'd36);
        @(posedge clk);
        #1;
        checkOutput("b2bIdleGap", busy, 1'b0);
        inA = 16'd9;
        inB = 16'd6;
        gcd = 16'd3;
        @(posedge clk);
        #1;
        checkOutput("b2bAccept", busy, 1'b1);
        start = 1'b0;
        waitDone(lat, bc);
        checkOutput("b2bSecondLat", lat, 33);
        checkOutput("b2bSecondLcm", lcm, 32'd18);
        repeat (3) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
